// File: rtl/one_wire_slave.sv
// 1-Wire device-side responder: reset/presence, write-slot decode into rx_byte, read-slot drive from tx_byte.
// Latency: bus edges seen 3 cycles late (2-flop sync + edge register); rx_valid/reset_seen 1 cycle after rising edge.
// Backpressure: tx_load accepted only while tx_ready=1; rx_byte is overwritten per byte, no stall. Optional ONE_WIRE_SLAVE_GLITCH_EN drops sub-1us lows.
module one_wire_slave #(
  parameter int CLK_MHZ    = 24,
  parameter int RST_MIN_US = 240,
  parameter int PD_WAIT_US = 30,
  parameter int PD_LOW_US  = 120,
  parameter int SAMPLE_US  = 30,
  parameter int TX0_US     = 45
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wire_in,
  output logic       wire_out,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic [7:0] tx_byte,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       reset_seen,
  output logic       busy
);

  localparam logic [15:0] RST_CYC     = 16'(CLK_MHZ * RST_MIN_US);
  localparam logic [15:0] PD_WAIT_CYC = 16'(CLK_MHZ * PD_WAIT_US);
  localparam logic [15:0] PD_LOW_CYC  = 16'(CLK_MHZ * PD_LOW_US);
  localparam logic [15:0] SAMPLE_CYC  = 16'(CLK_MHZ * SAMPLE_US);
  localparam logic [15:0] TX0_CYC     = 16'(CLK_MHZ * TX0_US);

  typedef enum logic [2:0] {IDLE, LOW, PD_WAIT, PD_LOW, PD_REL} state_t;

  state_t      state_q, state_d;
  logic        s1_q, s2_q, prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        reset_seen_q, reset_seen_d;
  logic        armed_q, armed_d;
  logic [7:0]  tx_q, tx_d;
  logic        mode_tx_q, mode_tx_d;
  logic        txbit_q, txbit_d;
  logic        fall, rise, is_glitch, drive_low;
  logic [7:0]  rx_shifted;

  assign fall = prev_q & ~s2_q;
  assign rise = ~prev_q & s2_q;
  assign rx_shifted = {(cnt_q < SAMPLE_CYC), rx_sh_q[7:1]};

`ifdef ONE_WIRE_SLAVE_GLITCH_EN
  localparam logic [15:0] GLITCH_CYC = 16'(CLK_MHZ);
  assign is_glitch = (cnt_q < GLITCH_CYC);
`else
  assign is_glitch = 1'b0;
`endif

  // Pull the bus low only for presence and for the hold phase of a '0' read slot.
  assign drive_low = (state_q == PD_LOW) ||
                     ((state_q == LOW) && mode_tx_q && !txbit_q && (cnt_q < TX0_CYC));
  assign wire_out   = drive_low ? 1'b0 : 1'bz;
  assign rx_byte    = rx_byte_q;
  assign rx_valid   = rx_valid_q;
  assign reset_seen = reset_seen_q;
  assign tx_ready   = ~armed_q;
  assign busy       = (state_q != IDLE);

  // Synchronizer, edge history and all registered state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q         <= 1'b1;
      s2_q         <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      rx_sh_q      <= '0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      reset_seen_q <= 1'b0;
      armed_q      <= 1'b0;
      tx_q         <= '0;
      mode_tx_q    <= 1'b0;
      txbit_q      <= 1'b1;
    end else begin
      s1_q         <= wire_in;
      s2_q         <= s1_q;
      prev_q       <= s2_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      rx_sh_q      <= rx_sh_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      reset_seen_q <= reset_seen_d;
      armed_q      <= armed_d;
      tx_q         <= tx_d;
      mode_tx_q    <= mode_tx_d;
      txbit_q      <= txbit_d;
    end
  end

  // Slot FSM: classify each low on its rising edge, and time the presence sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    bit_idx_d    = bit_idx_q;
    rx_sh_d      = rx_sh_q;
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = 1'b0;
    reset_seen_d = 1'b0;
    armed_d      = armed_q;
    tx_d         = tx_q;
    mode_tx_d    = mode_tx_q;
    txbit_d      = txbit_q;

    if (tx_load && !armed_q) begin
      armed_d = 1'b1;
      tx_d    = tx_byte;
    end

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = LOW;
          cnt_d     = '0;
          // A load in this very cycle already arms the slot.
          mode_tx_d = armed_q | tx_load;
          txbit_d   = armed_q ? tx_q[bit_idx_q] : tx_byte[bit_idx_q];
        end
      end
      LOW: begin
        if (rise) begin
          state_d = IDLE;
          if (cnt_q >= RST_CYC) begin
            state_d      = PD_WAIT;
            cnt_d        = '0;
            bit_idx_d    = '0;
            rx_sh_d      = '0;
            armed_d      = 1'b0;
            reset_seen_d = 1'b1;
          end else if (is_glitch) begin
            state_d = IDLE;
          end else if (!mode_tx_q) begin
            rx_sh_d   = rx_shifted;
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              rx_byte_d  = rx_shifted;
              rx_valid_d = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) armed_d = 1'b0;
          end
        end
      end
      PD_WAIT: begin
        if (cnt_q == PD_WAIT_CYC - 16'd1) begin
          state_d = PD_LOW;
          cnt_d   = '0;
        end
      end
      PD_LOW: begin
        if (cnt_q == PD_LOW_CYC - 16'd1) begin
          state_d = PD_REL;
          cnt_d   = '0;
        end
      end
      PD_REL: begin
        if (s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_one_wire_slave.sv
`timescale 1ns/1ps
module tb_one_wire_slave;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       master_low = 1'b0;
  logic       bus;
  wire        ow;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic       reset_seen;
  logic       busy;

  pullup (ow);
  assign bus = (master_low || (ow == 1'b0)) ? 1'b0 : 1'b1;

  one_wire_slave dut (
    .clk(clk), .reset_n(reset_n), .wire_in(bus), .wire_out(ow),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .tx_byte(tx_byte), .tx_load(tx_load),
    .tx_ready(tx_ready), .reset_seen(reset_seen), .busy(busy)
  );

  always #20.833 clk = ~clk;

  // Scoreboard events: 0 = received byte, 1 = reset detected, 2 = byte read back by the master.
  typedef struct {
    logic [1:0] kind;
    logic [7:0] dat;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  logic [7:0] rd_byte = 8'h00;
  logic       rd_vld  = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.dat  = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [1:0] k, input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.dat != d) begin
        errors++;
        $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h", k, d, e.kind, e.dat);
      end
    end
  endtask

  // Monitor: compare every DUT event (and master read-back) against the queue head.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid)   pop_cmp(2'd0, rx_byte);
      if (reset_seen) pop_cmp(2'd1, 8'h00);
      if (rd_vld)     pop_cmp(2'd2, rd_byte);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_reset();
    master_low = 1'b1;
    cyc(480 * 24);
    master_low = 1'b0;
    cyc(15 * 24);
    chk("pd_before", int'(ow), 1);
    cyc(45 * 24);
    chk("pd_low_60us", int'(ow), 0);
    cyc(80 * 24);
    chk("pd_low_140us", int'(ow), 0);
    cyc(30 * 24);
    chk("pd_after", int'(ow), 1);
    chk("idle_after_pd", int'(busy), 0);
    cyc(24 * 20);
  endtask

  task automatic write_bit(input logic b);
    for (int i = 0; i < 1680; i++) begin
      master_low = (i < (b ? 240 : 1440));
      cyc(1);
    end
    master_low = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) write_bit(v[i]);
  endtask

  // Master read: 2 us low, sample at 15 us, and measure how long the device pulls low.
  task automatic read_byte(input logic [7:0] expv);
    logic [7:0] r;
    int lowcnt;
    r = 8'h00;
    for (int b = 0; b < 8; b++) begin
      lowcnt = 0;
      master_low = 1'b1;
      for (int i = 0; i < 1680; i++) begin
        if (i == 48) master_low = 1'b0;
        if (i == 360) r[b] = bus;
        if (ow == 1'b0) lowcnt++;
        cyc(1);
      end
      if (expv[b]) chk($sformatf("tx_hold_bit%0d", b), lowcnt, 0);
      else chk($sformatf("tx_hold_bit%0d", b), int'(lowcnt >= 1075 && lowcnt <= 1090), 1);
    end
    rd_byte = r;
    rd_vld  = 1'b1;
    cyc(1);
    rd_vld  = 1'b0;
  endtask

  task automatic load(input logic [7:0] v);
    tx_byte = v;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
  endtask

  initial begin
    cyc(5);
    chk("rst_wire_out", int'(ow), 1);
    chk("rst_rx_byte", int'(rx_byte), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_tx_ready", int'(tx_ready), 1);
    chk("rst_reset_seen", int'(reset_seen), 0);
    chk("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    cyc(10);

    push(2'd1, 8'h00);
    bus_reset();

    push(2'd0, 8'hA5);
    write_byte(8'hA5, 8);

    load(8'h3C);
    chk("tx_ready_armed", int'(tx_ready), 0);
    push(2'd2, 8'h3C);
    read_byte(8'h3C);
    chk("tx_ready_done", int'(tx_ready), 1);

    write_byte(8'h05, 3);
    push(2'd1, 8'h00);
    bus_reset();
    push(2'd0, 8'h01);
    write_byte(8'h01, 8);

    load(8'hFF);
    load(8'h55);
    chk("tx_ready_ignored", int'(tx_ready), 0);
    push(2'd2, 8'hFF);
    read_byte(8'hFF);
    chk("tx_ready_ff_done", int'(tx_ready), 1);

    master_low = 1'b1;
    cyc(10);
    master_low = 1'b0;
    cyc(240);
`ifdef ONE_WIRE_SLAVE_GLITCH_EN
    push(2'd0, 8'h5A);
    write_byte(8'h5A, 8);
`else
    push(2'd0, 8'hB5);
    write_byte(8'h5A, 7);
`endif

    cyc(100);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
